// File: rtl/riscv_dmem_tcm_pkg.sv
// Shared types for the data-side TCM: bus size encoding, FSM states,
// response classification, buffered request record and byte-enable helper.
package riscv_dmem_tcm_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } biu_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_tcm_state_t;

  typedef enum logic [1:0] {
    RES_OK,
    RES_ERR,
    RES_MIS
  } dmem_tcm_res_t;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    biu_size_t   size;
    logic [31:0] d;
  } dmem_tcm_req_t;

  // Byte enables for a store of the given size at byte lane a.
  function automatic logic [3:0] size2be(biu_size_t size, logic [1:0] a);
    case (size)
      BYTE:    return 4'b0001 << a;
      HWORD:   return 4'b0011 << a;
      WORD:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_tcm_ram.sv
// Single-port synchronous RAM, four byte lanes of LW bits each (8, or 9 when
// a parity bit rides with every byte). Read data register only updates on a
// read access, so it holds the last load result while the FSM waits.
module riscv_dmem_tcm_ram #(
  parameter int DEPTH = 4096,
  parameter int LW    = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [AW-1:0]   addr,
  input  logic [4*LW-1:0] wdata,
  output logic [4*LW-1:0] rdata
);

  logic [4*LW-1:0] mem [DEPTH];
  logic [4*LW-1:0] rdata_q;

  // Byte-lane write or registered read, one access per cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/riscv_dmem_tcm.sv
// Data-side tightly coupled memory: responder on the core's dmem_* bus.
// Optional feature macro: RISCV_DMEM_PARITY_EN (per-byte even parity, error on
// load mismatch, adds dmem_par_inject input).
module riscv_dmem_tcm
  import riscv_dmem_tcm_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  input  logic [XLEN-1:0] dmem_d,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
`ifdef RISCV_DMEM_PARITY_EN
  ,
  input  logic            dmem_par_inject
`endif
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WINIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
`ifdef RISCV_DMEM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif

  dmem_tcm_state_t state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  dmem_tcm_req_t   pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  dmem_tcm_res_t   res_q, res_d;
  logic            rsp_we_q, rsp_we_d;

  dmem_tcm_req_t   live;
  dmem_tcm_req_t   acc;
  logic            accept;
  logic            acc_inj;
  logic [31:0]     acc_off;
  dmem_tcm_res_t   acc_res;

  logic            ram_we;
  logic [3:0]      ram_be;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word;
  logic [4*LW-1:0] ram_wdata;
  logic [4*LW-1:0] ram_rdata;
  logic            par_bad;

`ifdef RISCV_DMEM_PARITY_EN
  logic            pend_inj_q, pend_inj_d;
  logic [3:0]      lane_bad;
`endif

  assign live = '{adr: dmem_adr, we: dmem_we, size: dmem_size, d: dmem_d};

  // Pick the request accepted this cycle: live req from IDLE, pending first in RESP.
  always_comb begin
    accept = 1'b0;
    acc    = live;
`ifdef RISCV_DMEM_PARITY_EN
    acc_inj = dmem_par_inject;
`else
    acc_inj = 1'b0;
`endif
    case (state_q)
      IDLE: accept = dmem_req;
      RESP: begin
        accept = pend_vld_q | dmem_req;
        if (pend_vld_q) begin
          acc = pend_q;
`ifdef RISCV_DMEM_PARITY_EN
          acc_inj = pend_inj_q;
`endif
        end
      end
      default: ;
    endcase
  end

  // Classify the accepted request: illegal size, then alignment, then range.
  always_comb begin
    acc_off = acc.adr - BASE_ADDR;
    acc_res = RES_OK;
    if (!(acc.size inside {BYTE, HWORD, WORD})) begin
      acc_res = RES_ERR;
    end else if ((acc.size == HWORD && acc.adr[0]) ||
                 (acc.size == WORD && acc.adr[1:0] != 2'b00)) begin
      acc_res = RES_MIS;
    end else if (acc_off >= 32'(DEPTH * 4)) begin
      acc_res = RES_ERR;
    end
  end

  // Next-state: wait countdown, pending capture, response bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    res_d      = res_q;
    rsp_we_d   = rsp_we_q;
`ifdef RISCV_DMEM_PARITY_EN
    pend_inj_d = pend_inj_q;
`endif
    case (state_q)
      IDLE: ;
      WAIT: begin
        if (dmem_req && !pend_vld_q) begin
          pend_d     = live;
          pend_vld_d = 1'b1;
`ifdef RISCV_DMEM_PARITY_EN
          pend_inj_d = dmem_par_inject;
`endif
        end
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RESP: begin
        state_d = IDLE;
        // Pending is being consumed; a simultaneous live req refills it.
        if (pend_vld_q) begin
          pend_vld_d = dmem_req;
          if (dmem_req) begin
            pend_d = live;
`ifdef RISCV_DMEM_PARITY_EN
            pend_inj_d = dmem_par_inject;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      res_d    = acc_res;
      rsp_we_d = acc.we;
      cnt_d    = 3'(WINIT);
      state_d  = (WAIT_STATES > 0) ? WAIT : RESP;
    end
  end

  // Control state with asynchronous reset; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      pend_vld_q <= 1'b0;
      res_q      <= RES_OK;
      rsp_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      res_q      <= res_d;
      rsp_we_q   <= rsp_we_d;
    end
  end

  // Pending request payload; only meaningful while pend_vld_q is set.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
`ifdef RISCV_DMEM_PARITY_EN
    pend_inj_q <= pend_inj_d;
`endif
  end

  // Array access happens in the acceptance cycle; faulting stores are masked.
  assign wr_word  = acc.d << {acc.adr[1:0], 3'b000};
  assign ram_we   = accept && acc.we && (acc_res == RES_OK);
  assign ram_be   = size2be(acc.size, acc.adr[1:0]);
  assign ram_addr = AW'(acc_off >> 2);

  for (genvar i = 0; i < 4; i++) begin : g_lane
`ifdef RISCV_DMEM_PARITY_EN
    assign ram_wdata[i*LW +: LW] = {(^wr_word[i*8 +: 8]) ^ ((i == 0) ? acc_inj : 1'b0),
                                    wr_word[i*8 +: 8]};
    assign lane_bad[i]           = ^ram_rdata[i*LW +: LW];
`else
    assign ram_wdata[i*LW +: LW] = wr_word[i*8 +: 8];
`endif
    assign rd_word[i*8 +: 8]     = ram_rdata[i*LW +: 8];
  end

`ifdef RISCV_DMEM_PARITY_EN
  assign par_bad = |lane_bad;
`else
  assign par_bad = 1'b0;
  logic unused_inj;
  assign unused_inj = acc_inj;
`endif

  riscv_dmem_tcm_ram #(
    .DEPTH (DEPTH),
    .LW    (LW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Response pulse: exactly one flag in RESP, load data only alongside ack.
  always_comb begin
    dmem_ack        = 1'b0;
    dmem_err        = 1'b0;
    dmem_misaligned = 1'b0;
    dmem_q          = '0;
    if (state_q == RESP) begin
      case (res_q)
        RES_OK: begin
          if (!rsp_we_q && par_bad) begin
            dmem_err = 1'b1;
          end else begin
            dmem_ack = 1'b1;
            if (!rsp_we_q) dmem_q = XLEN'(rd_word);
          end
        end
        RES_MIS: dmem_misaligned = 1'b1;
        default: dmem_err        = 1'b1;
      endcase
    end
  end

  assign dmem_page_fault = 1'b0;

  // The core never issues a request while the pending slot is full in WAIT.
  a_no_drop: assert property (@(posedge clk) disable iff (rst)
                              !(dmem_req && pend_vld_q && state_q == WAIT));

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Bench for riscv_dmem_tcm: a zero-wait instance for the functional table and
// random traffic, a three-wait instance for latency, pending and reset cases.
module tb_riscv_dmem_tcm;
  import riscv_dmem_tcm_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic [31:0] adr = '0, d = '0;
  logic        we = 1'b0;
  biu_size_t   size = WORD;
  logic        inj = 1'b0;
  logic [31:0] q0, q3;
  logic        ack0, err0, mis0, pf0, ack3, err3, mis3, pf3;
  logic [35:0] o0, o3;

  int total = 0;
  int bad = 0;
  logic [7:0] mb [DEPTH*4];

  always #5 clk = ~clk;

  assign o0 = {pf0, ack0, err0, mis0, q0};
  assign o3 = {pf3, ack3, err3, mis3, q3};

  riscv_dmem_tcm #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .dmem_req(req0), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .dmem_q(q0), .dmem_ack(ack0), .dmem_err(err0),
    .dmem_misaligned(mis0), .dmem_page_fault(pf0)
`ifdef RISCV_DMEM_PARITY_EN
    , .dmem_par_inject(inj)
`endif
  );

  riscv_dmem_tcm #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .dmem_req(req3), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .dmem_q(q3), .dmem_ack(ack3), .dmem_err(err3),
    .dmem_misaligned(mis3), .dmem_page_fault(pf3)
`ifdef RISCV_DMEM_PARITY_EN
    , .dmem_par_inject(inj)
`endif
  );

  function automatic logic [35:0] rsp(input logic a, input logic e, input logic m,
                                      input logic [31:0] q);
    return {1'b0, a, e, m, q};
  endfunction

  // Reference: byte-addressed memory, size/alignment/range rules as arithmetic.
  function automatic logic [35:0] model(input logic w, input logic [1:0] sz,
                                        input logic [31:0] a, input logic [31:0] dd);
    logic [31:0] o;
    int n, bi;
    o = a - BASE;
    if (sz == 2'd3) return rsp(1'b0, 1'b1, 1'b0, 32'h0);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (a % n != 0) return rsp(1'b0, 1'b0, 1'b1, 32'h0);
    if (o >= DEPTH * 4) return rsp(1'b0, 1'b1, 1'b0, 32'h0);
    if (w) begin
      for (int k = 0; k < n; k++) mb[int'(o) + k] = dd[8*k +: 8];
      return rsp(1'b1, 1'b0, 1'b0, 32'h0);
    end
    bi = int'(o) & ~3;
    return rsp(1'b1, 1'b0, 1'b0, {mb[bi+3], mb[bi+2], mb[bi+1], mb[bi]});
  endfunction

  task automatic cmp(input string nm, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] dd);
    we = w; size = biu_size_t'(sz); adr = a; d = dd;
  endtask

  // One zero-wait op; response is visible right after the accepting edge.
  task automatic issue0(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] dd);
    drive(w, sz, a, dd);
    req0 = 1'b1;
    cyc();
  endtask

  // Wait (bounded) for the three-wait instance to respond, then compare.
  task automatic wait3(input string nm, input logic [35:0] exp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(ack3 | err3 | mis3) && n < 20);
    cmp(nm, o3, exp);
  endtask

  task automatic op3(input string nm, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] dd, input logic [35:0] exp);
    drive(w, sz, a, dd);
    req3 = 1'b1;
    cyc();
    req3 = 1'b0;
    wait3(nm, exp);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] off;
    logic [31:0] d;
    logic [35:0] exp;
  } vec_t;

  vec_t tv[20];

  initial begin
    logic [35:0] e;
    logic [31:0] o;
    logic [1:0]  sz;
    logic        w;
    int          r, n;

    tv[0]  = '{1'b1, 2'd2, 32'h10,  32'hDEADBEEF, rsp(1, 0, 0, 32'h0)};
    tv[1]  = '{1'b0, 2'd2, 32'h10,  32'h0,        rsp(1, 0, 0, 32'hDEADBEEF)};
    tv[2]  = '{1'b1, 2'd0, 32'h13,  32'h0000005A, rsp(1, 0, 0, 32'h0)};
    tv[3]  = '{1'b0, 2'd2, 32'h10,  32'h0,        rsp(1, 0, 0, 32'h5AADBEEF)};
    tv[4]  = '{1'b1, 2'd1, 32'h10,  32'h00001234, rsp(1, 0, 0, 32'h0)};
    tv[5]  = '{1'b0, 2'd2, 32'h10,  32'h0,        rsp(1, 0, 0, 32'h5AAD1234)};
    tv[6]  = '{1'b1, 2'd1, 32'h11,  32'h0000FFFF, rsp(0, 0, 1, 32'h0)};
    tv[7]  = '{1'b0, 2'd2, 32'h10,  32'h0,        rsp(1, 0, 0, 32'h5AAD1234)};
    tv[8]  = '{1'b0, 2'd2, 32'h100, 32'h0,        rsp(0, 1, 0, 32'h0)};
    tv[9]  = '{1'b1, 2'd2, 32'hFFFFFFFC, 32'h1,   rsp(0, 1, 0, 32'h0)};
    tv[10] = '{1'b0, 2'd3, 32'h10,  32'h0,        rsp(0, 1, 0, 32'h0)};
    tv[11] = '{1'b0, 2'd3, 32'h11,  32'h0,        rsp(0, 1, 0, 32'h0)};
    tv[12] = '{1'b0, 2'd2, 32'h12,  32'h0,        rsp(0, 0, 1, 32'h0)};
    tv[13] = '{1'b1, 2'd2, 32'h101, 32'h0,        rsp(0, 0, 1, 32'h0)};
    tv[14] = '{1'b1, 2'd0, 32'h11,  32'h00000077, rsp(1, 0, 0, 32'h0)};
    tv[15] = '{1'b0, 2'd1, 32'h12,  32'h0,        rsp(1, 0, 0, 32'h5AAD7734)};
    tv[16] = '{1'b1, 2'd1, 32'h12,  32'h0000ABCD, rsp(1, 0, 0, 32'h0)};
    tv[17] = '{1'b0, 2'd0, 32'h10,  32'h0,        rsp(1, 0, 0, 32'hABCD7734)};
    tv[18] = '{1'b1, 2'd2, 32'hFC,  32'h87654321, rsp(1, 0, 0, 32'h0)};
    tv[19] = '{1'b0, 2'd2, 32'hFC,  32'h0,        rsp(1, 0, 0, 32'h87654321)};

    // Reset state
    cyc(); cyc();
    cmp("reset_w0", o0, 36'h0);
    cmp("reset_w3", o3, 36'h0);
    rst = 1'b0;
    cyc();

    // Directed table, back-to-back on the zero-wait instance
    for (int i = 0; i < 20; i++) begin
      issue0(tv[i].we, tv[i].sz, BASE + tv[i].off, tv[i].d);
      cmp($sformatf("vec%0d", i), o0, tv[i].exp);
    end
    req0 = 1'b0;
    cyc();
    cmp("idle_after_table", o0, 36'h0);

`ifdef RISCV_DMEM_PARITY_EN
    inj = 1'b1;
    issue0(1'b1, 2'd2, BASE + 32'h20, 32'h0BADF00D);
    inj = 1'b0;
    cmp("par_store_inj", o0, rsp(1, 0, 0, 32'h0));
    issue0(1'b0, 2'd2, BASE + 32'h20, 32'h0);
    cmp("par_load_err", o0, rsp(0, 1, 0, 32'h0));
    issue0(1'b1, 2'd2, BASE + 32'h20, 32'h13579BDF);
    cmp("par_rewrite", o0, rsp(1, 0, 0, 32'h0));
    issue0(1'b0, 2'd2, BASE + 32'h20, 32'h0);
    cmp("par_load_ok", o0, rsp(1, 0, 0, 32'h13579BDF));
    req0 = 1'b0;
    cyc();
`endif

    // Random traffic against the byte model over a 64-byte window
    for (int i = 0; i < 16; i++) begin
      o = 32'(i * 4);
      d = $urandom;
      e = model(1'b1, 2'd2, BASE + o, d);
      issue0(1'b1, 2'd2, BASE + o, d);
      cmp($sformatf("init%0d", i), o0, e);
    end
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 19);
      if (r == 0)      o = 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
      else if (r == 1) o = 32'hFFFFFFFC;
      else             o = 32'($urandom_range(0, 63));
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) o = o & ~32'(n - 1);
      d = $urandom;
      e = model(w, sz, BASE + o, d);
      issue0(w, sz, BASE + o, d);
      cmp($sformatf("rand%0d", i), o0, e);
    end
    req0 = 1'b0;
    cyc();

    // Three-wait instance: latency, pending capture, pending+live in RESP
    op3("w3_pre0", 1'b1, 2'd2, BASE + 32'h10, 32'hCAFEF00D, rsp(1, 0, 0, 32'h0));
    op3("w3_pre1", 1'b1, 2'd2, BASE + 32'h14, 32'h11223344, rsp(1, 0, 0, 32'h0));
    op3("w3_pre2", 1'b1, 2'd2, BASE + 32'h18, 32'h55667788, rsp(1, 0, 0, 32'h0));
    cyc();
    drive(1'b0, 2'd2, BASE + 32'h10, 32'h0);
    req3 = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      req3 = 1'b0;
      if (c == 4)       e = rsp(1, 0, 0, 32'hCAFEF00D);
      else if (c == 8)  e = rsp(1, 0, 0, 32'h11223344);
      else if (c == 12) e = rsp(1, 0, 0, 32'h55667788);
      else              e = 36'h0;
      cmp($sformatf("w3_cyc%0d", c), o3, e);
      if (c == 2) begin drive(1'b0, 2'd2, BASE + 32'h14, 32'h0); req3 = 1'b1; end
      if (c == 4) begin drive(1'b0, 2'd2, BASE + 32'h18, 32'h0); req3 = 1'b1; end
    end

    // Reset while a load is waiting
    op3("w3_pre3", 1'b1, 2'd2, BASE + 32'h1C, 32'hA5A50001, rsp(1, 0, 0, 32'h0));
    drive(1'b0, 2'd2, BASE + 32'h1C, 32'h0);
    req3 = 1'b1;
    cyc();
    req3 = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    cmp("rst_mid_w3", o3, 36'h0);
    cmp("rst_mid_w0", o0, 36'h0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      cmp($sformatf("post_rst%0d", c), o3, 36'h0);
    end
    op3("w3_persist", 1'b0, 2'd2, BASE + 32'h1C, 32'h0, rsp(1, 0, 0, 32'hA5A50001));
    e = model(1'b0, 2'd2, BASE + 32'h0, 32'h0);
    issue0(1'b0, 2'd2, BASE + 32'h0, 32'h0);
    req0 = 1'b0;
    cmp("w0_persist", o0, e);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
